// File: rtl/dog_anim_ctrl.sv
`timescale 1ns/1ps
// Dog sprite animation sequencer: intro walk/sniff/jump and the between-rounds peek.
// Motion advances once per frame_tick; every output is driven straight from a register.
module dog_anim_ctrl #(
  parameter int X_START         = 0,
  parameter int X_SNIFF         = 200,
  parameter int STEP_PX         = 2,
  parameter int FRAMES_PER_STEP = 6,
  parameter int SNIFF_FRAMES    = 30,
  parameter int JUMP_FRAMES     = 16,
  parameter int JUMP_PX         = 3,
  parameter int Y_GROUND        = 560,
  parameter int Y_HIDE          = 600,
  parameter int PEEK_FRAMES     = 20,
  parameter int PEEK_PX         = 2,
  parameter int HOLD_FRAMES     = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        start_intro,
  input  logic        req_bird,
  input  logic        req_laugh,
  input  logic [11:0] peek_x,
  input  logic        abort,
  output logic [3:0]  dog_select,
  output logic        dog_bird_mode,
  output logic [11:0] dog_xpos,
  output logic [11:0] dog_ypos,
  output logic        dog_visible,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WALK      = 4'd1,
    ST_SNIFF     = 4'd2,
    ST_JUMP_UP   = 4'd3,
    ST_JUMP_DOWN = 4'd4,
    ST_HIDDEN    = 4'd5,
    ST_PEEK_RISE = 4'd6,
    ST_PEEK_HOLD = 4'd7,
    ST_PEEK_FALL = 4'd8
  } state_t;

  localparam logic [11:0] X_START_W  = 12'(X_START);
  localparam logic [11:0] X_SNIFF_W  = 12'(X_SNIFF);
  localparam logic [11:0] STEP_W     = 12'(STEP_PX);
  localparam logic [11:0] JUMP_W     = 12'(JUMP_PX);
  localparam logic [11:0] PEEK_W     = 12'(PEEK_PX);
  localparam logic [11:0] Y_GROUND_W = 12'(Y_GROUND);
  localparam logic [11:0] Y_HIDE_W   = 12'(Y_HIDE);
  localparam logic [2:0]  ANIM_LAST  = 3'(FRAMES_PER_STEP - 1);
  localparam logic [7:0]  SNIFF_LAST = 8'(SNIFF_FRAMES - 1);
  localparam logic [7:0]  JUMP_LAST  = 8'(JUMP_FRAMES - 1);
  localparam logic [7:0]  PEEK_LAST  = 8'(PEEK_FRAMES - 1);
  localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_FRAMES - 1);

  localparam logic [3:0] SEL_WALK0     = 4'd0;
  localparam logic [3:0] SEL_SNIFF     = 4'd4;
  localparam logic [3:0] SEL_JUMP_UP   = 4'd5;
  localparam logic [3:0] SEL_JUMP_DOWN = 4'd6;
  localparam logic [3:0] SEL_LAUGH_A   = 4'd7;
  localparam logic [3:0] SEL_LAUGH_B   = 4'd8;

  // Laughing pose alternates between its two ROM frames
  function automatic logic [3:0] laugh_toggle(input logic [3:0] sel);
    return (sel == SEL_LAUGH_A) ? SEL_LAUGH_B : SEL_LAUGH_A;
  endfunction

  state_t      state_r, state_s;
  logic [7:0]  tick_cnt_r, tick_cnt_s;
  logic [2:0]  anim_cnt_r, anim_cnt_s;
  logic [3:0]  select_r, select_s;
  logic        bird_r, bird_s;
  logic [11:0] x_r, x_s;
  logic [11:0] y_r, y_s;
  logic        visible_r, visible_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic [11:0] x_step_s;
  logic        anim_wrap_s;

  assign x_step_s    = x_r + STEP_W;
  assign anim_wrap_s = frame_tick && (anim_cnt_r == ANIM_LAST);

  // Next-state and next-output logic; abort outranks ticks and requests
  always_comb begin
    state_s   = state_r;
    select_s  = select_r;
    bird_s    = bird_r;
    x_s       = x_r;
    y_s       = y_r;
    visible_s = visible_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    if (abort && (state_r != ST_IDLE)) begin
      state_s   = ST_HIDDEN;
      visible_s = 1'b0;
      busy_s    = 1'b0;
      bird_s    = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_intro) begin
            state_s   = ST_WALK;
            x_s       = X_START_W;
            y_s       = Y_GROUND_W;
            select_s  = SEL_WALK0;
            visible_s = 1'b1;
            busy_s    = 1'b1;
            bird_s    = 1'b0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_WALK: begin
          if (frame_tick) begin
            if (x_step_s >= X_SNIFF_W) begin
              x_s      = X_SNIFF_W;
              select_s = SEL_SNIFF;
              state_s  = ST_SNIFF;
            end else if (anim_wrap_s) begin
              x_s      = x_step_s;
              select_s = {2'b00, select_r[1:0] + 2'd1};
            end else begin
              x_s = x_step_s;
            end
          end else begin
            state_s = ST_WALK;
          end
        end
        ST_SNIFF: begin
          if (frame_tick && (tick_cnt_r == SNIFF_LAST)) begin
            state_s  = ST_JUMP_UP;
            select_s = SEL_JUMP_UP;
          end else begin
            state_s = ST_SNIFF;
          end
        end
        ST_JUMP_UP: begin
          if (frame_tick) begin
            y_s = y_r - JUMP_W;
            if (tick_cnt_r == JUMP_LAST) begin
              state_s  = ST_JUMP_DOWN;
              select_s = SEL_JUMP_DOWN;
            end else begin
              state_s = ST_JUMP_UP;
            end
          end else begin
            state_s = ST_JUMP_UP;
          end
        end
        ST_JUMP_DOWN: begin
          if (frame_tick) begin
            y_s = y_r + JUMP_W;
            if (tick_cnt_r == JUMP_LAST) begin
              state_s   = ST_HIDDEN;
              visible_s = 1'b0;
              busy_s    = 1'b0;
              bird_s    = 1'b0;
              done_s    = 1'b1;
            end else begin
              state_s = ST_JUMP_DOWN;
            end
          end else begin
            state_s = ST_JUMP_DOWN;
          end
        end
        ST_HIDDEN: begin
          if (start_intro) begin
            state_s   = ST_WALK;
            x_s       = X_START_W;
            y_s       = Y_GROUND_W;
            select_s  = SEL_WALK0;
            visible_s = 1'b1;
            busy_s    = 1'b1;
            bird_s    = 1'b0;
          end else if (req_bird || req_laugh) begin
            state_s   = ST_PEEK_RISE;
            x_s       = peek_x;
            y_s       = Y_HIDE_W;
            visible_s = 1'b1;
            busy_s    = 1'b1;
            bird_s    = req_bird;
            select_s  = req_bird ? SEL_WALK0 : SEL_LAUGH_A;
          end else begin
            state_s = ST_HIDDEN;
          end
        end
        ST_PEEK_RISE: begin
          if (frame_tick) begin
            y_s = y_r - PEEK_W;
            if (tick_cnt_r == PEEK_LAST) begin
              state_s = ST_PEEK_HOLD;
            end else begin
              state_s = ST_PEEK_RISE;
            end
          end else begin
            state_s = ST_PEEK_RISE;
          end
        end
        ST_PEEK_HOLD: begin
          if (frame_tick) begin
            select_s = (!bird_r && anim_wrap_s) ? laugh_toggle(select_r) : select_r;
            if (tick_cnt_r == HOLD_LAST) begin
              state_s = ST_PEEK_FALL;
            end else begin
              state_s = ST_PEEK_HOLD;
            end
          end else begin
            state_s = ST_PEEK_HOLD;
          end
        end
        ST_PEEK_FALL: begin
          if (frame_tick) begin
            y_s      = y_r + PEEK_W;
            select_s = (!bird_r && anim_wrap_s) ? laugh_toggle(select_r) : select_r;
            if (tick_cnt_r == PEEK_LAST) begin
              state_s   = ST_HIDDEN;
              visible_s = 1'b0;
              busy_s    = 1'b0;
              bird_s    = 1'b0;
              done_s    = 1'b1;
            end else begin
              state_s = ST_PEEK_FALL;
            end
          end else begin
            state_s = ST_PEEK_FALL;
          end
        end
        default: begin
          state_s   = ST_IDLE;
          visible_s = 1'b0;
          busy_s    = 1'b0;
          bird_s    = 1'b0;
        end
      endcase
    end
  end

  // Tick and animation timers: advance on frame_tick, clear on any state change
  always_comb begin
    if (state_s != state_r) begin
      tick_cnt_s = 8'd0;
      anim_cnt_s = 3'd0;
    end else if (frame_tick) begin
      tick_cnt_s = tick_cnt_r + 8'd1;
      anim_cnt_s = anim_wrap_s ? 3'd0 : anim_cnt_r + 3'd1;
    end else begin
      tick_cnt_s = tick_cnt_r;
      anim_cnt_s = anim_cnt_r;
    end
  end

  // State, timer and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      tick_cnt_r <= 8'd0;
      anim_cnt_r <= 3'd0;
      select_r   <= SEL_WALK0;
      bird_r     <= 1'b0;
      x_r        <= X_START_W;
      y_r        <= Y_GROUND_W;
      visible_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      tick_cnt_r <= tick_cnt_s;
      anim_cnt_r <= anim_cnt_s;
      select_r   <= select_s;
      bird_r     <= bird_s;
      x_r        <= x_s;
      y_r        <= y_s;
      visible_r  <= visible_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign dog_select    = select_r;
  assign dog_bird_mode = bird_r;
  assign dog_xpos      = x_r;
  assign dog_ypos      = y_r;
  assign dog_visible   = visible_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: tb/tb_dog_anim_ctrl.sv
`timescale 1ns/1ps
// Bench for dog_anim_ctrl: directed scenarios plus random traffic checked against
// a model that derives pose from (phase, ticks elapsed in phase) with plain arithmetic.
module tb_dog_anim_ctrl;
  localparam int X_START = 0, X_SNIFF = 200, STEP_PX = 2, FRAMES_PER_STEP = 6;
  localparam int SNIFF_FRAMES = 30, JUMP_FRAMES = 16, JUMP_PX = 3, Y_GROUND = 560;
  localparam int Y_HIDE = 600, PEEK_FRAMES = 20, PEEK_PX = 2, HOLD_FRAMES = 60;

  logic clk = 1'b0;
  logic rst_n = 1'b0, frame_tick = 1'b0, start_intro = 1'b0;
  logic req_bird = 1'b0, req_laugh = 1'b0, abort = 1'b0;
  logic [11:0] peek_x = 12'd0;
  logic [3:0]  dog_select;
  logic        dog_bird_mode, dog_visible, busy, done;
  logic [11:0] dog_xpos, dog_ypos;
  int checks = 0, errors = 0;

  dog_anim_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start_intro(start_intro),
    .req_bird(req_bird), .req_laugh(req_laugh), .peek_x(peek_x), .abort(abort),
    .dog_select(dog_select), .dog_bird_mode(dog_bird_mode), .dog_xpos(dog_xpos),
    .dog_ypos(dog_ypos), .dog_visible(dog_visible), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: phase plus ticks counted since the phase began
  localparam int P_IDLE = 0, P_WALK = 1, P_SNIFF = 2, P_UP = 3, P_DOWN = 4;
  localparam int P_HIDDEN = 5, P_RISE = 6, P_HOLD = 7, P_FALL = 8;
  int m_phase = P_IDLE, m_n = 0, m_x = X_START, m_y = Y_GROUND, m_sel = 0, m_base = 7;
  bit m_bird = 1'b0, m_done = 1'b0;

  function automatic int laugh_pose(int base, int n);
    if (((n / FRAMES_PER_STEP) % 2) == 1) return (base == 7) ? 8 : 7;
    else return base;
  endfunction

  task automatic go(int p);
    m_phase = p;
    m_n = 0;
  endtask

  task automatic begin_walk();
    go(P_WALK);
    m_x = X_START; m_y = Y_GROUND; m_sel = 0; m_bird = 1'b0;
  endtask

  task automatic advance();
    m_n++;
    case (m_phase)
      P_WALK: begin
        m_x = X_START + STEP_PX * m_n;
        if (m_x >= X_SNIFF) begin m_x = X_SNIFF; go(P_SNIFF); m_sel = 4; end
        else m_sel = (m_n / FRAMES_PER_STEP) % 4;
      end
      P_SNIFF: if (m_n == SNIFF_FRAMES) begin go(P_UP); m_sel = 5; end
      P_UP: begin
        m_y = Y_GROUND - JUMP_PX * m_n;
        if (m_n == JUMP_FRAMES) begin go(P_DOWN); m_sel = 6; end
      end
      P_DOWN: begin
        m_y = Y_GROUND - JUMP_PX * JUMP_FRAMES + JUMP_PX * m_n;
        if (m_n == JUMP_FRAMES) begin go(P_HIDDEN); m_bird = 1'b0; m_done = 1'b1; end
      end
      P_RISE: begin
        m_y = Y_HIDE - PEEK_PX * m_n;
        if (m_n == PEEK_FRAMES) begin go(P_HOLD); m_base = m_sel; end
      end
      P_HOLD: begin
        if (!m_bird) m_sel = laugh_pose(m_base, m_n);
        if (m_n == HOLD_FRAMES) begin go(P_FALL); m_base = m_sel; end
      end
      P_FALL: begin
        m_y = Y_HIDE - PEEK_PX * PEEK_FRAMES + PEEK_PX * m_n;
        if (!m_bird) m_sel = laugh_pose(m_base, m_n);
        if (m_n == PEEK_FRAMES) begin go(P_HIDDEN); m_bird = 1'b0; m_done = 1'b1; end
      end
      default: ;
    endcase
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (!rst_n) begin
      go(P_IDLE); m_x = X_START; m_y = Y_GROUND; m_sel = 0; m_bird = 1'b0;
    end else if (abort && m_phase != P_IDLE) begin
      go(P_HIDDEN); m_bird = 1'b0;
    end else if (m_phase == P_IDLE || m_phase == P_HIDDEN) begin
      if (start_intro) begin_walk();
      else if (m_phase == P_HIDDEN && (req_bird || req_laugh)) begin
        go(P_RISE); m_x = peek_x; m_y = Y_HIDE; m_bird = req_bird; m_sel = req_bird ? 0 : 7;
      end
    end else if (frame_tick) begin
      advance();
    end
  endtask

  // One clock: model consumes the current inputs, DUT sampled 1ns after the edge
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b0; cyc();
      frame_tick = 1'b1; cyc();
      frame_tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cyc(); cyc(); cyc(); rst_n = 1'b1;
    checks++; if (dog_select !== 4'd0) begin errors++; $display("FAIL rst_select got %0d need 0", dog_select); end
    checks++; if (dog_bird_mode !== 1'b0) begin errors++; $display("FAIL rst_bird got %0b need 0", dog_bird_mode); end
    checks++; if (dog_xpos !== 12'd0) begin errors++; $display("FAIL rst_x got %0d need 0", dog_xpos); end
    checks++; if (dog_ypos !== 12'd560) begin errors++; $display("FAIL rst_y got %0d need 560", dog_ypos); end
    checks++; if (dog_visible !== 1'b0) begin errors++; $display("FAIL rst_visible got %0b need 0", dog_visible); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_busy_done got %0b%0b need 00", busy, done); end
    start_intro = 1'b1; cyc(); start_intro = 1'b0;
    tick_n(100 + 30 + 5);
    checks++; if (dog_ypos !== 12'd545) begin errors++; $display("FAIL midjump_y got %0d need 545", dog_ypos); end
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    checks++; if (dog_select !== 4'd0 || dog_xpos !== 12'd0 || dog_ypos !== 12'd560) begin
      errors++; $display("FAIL midrst_pose got sel %0d x %0d y %0d need 0 0 560", dog_select, dog_xpos, dog_ypos); end
    checks++; if (dog_visible !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_vis_busy got %0b%0b need 00", dog_visible, busy); end
    req_bird = 1'b1; peek_x = 12'd77; cyc(); req_bird = 1'b0; cyc();
    checks++; if (dog_visible !== 1'b0 || busy !== 1'b0 || dog_bird_mode !== 1'b0) begin
      errors++; $display("FAIL idle_req_ignored got vis %0b busy %0b bird %0b need 000", dog_visible, busy, dog_bird_mode); end
  endtask

  task automatic test_intro();
    start_intro = 1'b1; cyc(); start_intro = 1'b0;
    checks++; if (dog_visible !== 1'b1 || busy !== 1'b1 || dog_xpos !== 12'd0 || dog_select !== 4'd0) begin
      errors++; $display("FAIL walk_entry got vis %0b busy %0b x %0d sel %0d need 1 1 0 0", dog_visible, busy, dog_xpos, dog_select); end
    tick_n(99);
    checks++; if (dog_xpos !== 12'd198 || dog_select !== 4'd0) begin
      errors++; $display("FAIL walk_99 got x %0d sel %0d need 198 0", dog_xpos, dog_select); end
    tick_n(1);
    checks++; if (dog_xpos !== 12'd200 || dog_select !== 4'd4) begin
      errors++; $display("FAIL sniff_entry got x %0d sel %0d need 200 4", dog_xpos, dog_select); end
    tick_n(29);
    checks++; if (dog_select !== 4'd4) begin errors++; $display("FAIL sniff_29 got sel %0d need 4", dog_select); end
    tick_n(1);
    checks++; if (dog_select !== 4'd5 || dog_ypos !== 12'd560) begin
      errors++; $display("FAIL jump_entry got sel %0d y %0d need 5 560", dog_select, dog_ypos); end
    tick_n(16);
    checks++; if (dog_ypos !== 12'd512 || dog_select !== 4'd6) begin
      errors++; $display("FAIL jump_top got y %0d sel %0d need 512 6", dog_ypos, dog_select); end
    tick_n(15);
    checks++; if (dog_ypos !== 12'd557 || dog_visible !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL jump_15 got y %0d vis %0b done %0b need 557 1 0", dog_ypos, dog_visible, done); end
    tick_n(1);
    checks++; if (dog_ypos !== 12'd560 || dog_visible !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL intro_end got y %0d vis %0b busy %0b done %0b need 560 0 0 1", dog_ypos, dog_visible, busy, done); end
    cyc();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL intro_done_width got %0b need 0", done); end
  endtask

  task automatic test_peek_bird();
    peek_x = 12'd300; req_bird = 1'b1; req_laugh = 1'b1; cyc(); req_bird = 1'b0; req_laugh = 1'b0;
    checks++; if (dog_bird_mode !== 1'b1 || dog_xpos !== 12'd300 || dog_ypos !== 12'd600 || dog_select !== 4'd0) begin
      errors++; $display("FAIL bird_accept got bird %0b x %0d y %0d sel %0d need 1 300 600 0", dog_bird_mode, dog_xpos, dog_ypos, dog_select); end
    checks++; if (dog_visible !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL bird_vis_busy got %0b%0b need 11", dog_visible, busy); end
    tick_n(20);
    checks++; if (dog_ypos !== 12'd560) begin errors++; $display("FAIL bird_risen got y %0d need 560", dog_ypos); end
    tick_n(60);
    checks++; if (dog_ypos !== 12'd560 || busy !== 1'b1 || dog_select !== 4'd0) begin
      errors++; $display("FAIL bird_held got y %0d busy %0b sel %0d need 560 1 0", dog_ypos, busy, dog_select); end
    tick_n(19);
    checks++; if (dog_ypos !== 12'd598 || done !== 1'b0) begin
      errors++; $display("FAIL bird_fall19 got y %0d done %0b need 598 0", dog_ypos, done); end
    tick_n(1);
    checks++; if (dog_ypos !== 12'd600 || dog_visible !== 1'b0 || done !== 1'b1 || dog_bird_mode !== 1'b0) begin
      errors++; $display("FAIL bird_end got y %0d vis %0b done %0b bird %0b need 600 0 1 0", dog_ypos, dog_visible, done, dog_bird_mode); end
    cyc();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL bird_done_width got %0b need 0", done); end
  endtask

  task automatic test_peek_laugh();
    logic [11:0] px;
    int toggles;
    logic [3:0] prev, exp_sel;
    px = 12'($urandom_range(0, 4095));
    peek_x = px; req_laugh = 1'b1; cyc(); req_laugh = 1'b0;
    checks++; if (dog_select !== 4'd7 || dog_bird_mode !== 1'b0 || dog_xpos !== px) begin
      errors++; $display("FAIL laugh_accept got sel %0d bird %0b x %0d need 7 0 %0d", dog_select, dog_bird_mode, dog_xpos, px); end
    tick_n(20);
    checks++; if (dog_select !== 4'd7 || dog_ypos !== 12'd560) begin
      errors++; $display("FAIL laugh_risen got sel %0d y %0d need 7 560", dog_select, dog_ypos); end
    toggles = 0;
    prev = dog_select;
    for (int k = 1; k <= 60; k++) begin
      tick_n(1);
      exp_sel = (((k / 6) % 2) == 1) ? 4'd8 : 4'd7;
      checks++; if (dog_select !== exp_sel) begin
        errors++; $display("FAIL laugh_hold_sel tick %0d got %0d need %0d", k, dog_select, exp_sel); end
      if (dog_select !== prev) toggles++;
      prev = dog_select;
      if (k == 30) begin
        req_bird = 1'b1; peek_x = 12'd5; cyc(); req_bird = 1'b0;
        checks++; if (dog_bird_mode !== 1'b0 || dog_xpos !== px || busy !== 1'b1) begin
          errors++; $display("FAIL laugh_drop_req got bird %0b x %0d busy %0b need 0 %0d 1", dog_bird_mode, dog_xpos, busy, px); end
      end
    end
    checks++; if (toggles != 10 || dog_ypos !== 12'd560) begin
      errors++; $display("FAIL laugh_toggles got %0d y %0d need 10 560", toggles, dog_ypos); end
    tick_n(20);
    checks++; if (dog_ypos !== 12'd600 || done !== 1'b1 || dog_select !== 4'd8) begin
      errors++; $display("FAIL laugh_end got y %0d done %0b sel %0d need 600 1 8", dog_ypos, done, dog_select); end
  endtask

  task automatic test_abort();
    start_intro = 1'b1; cyc(); start_intro = 1'b0;
    tick_n(50);
    checks++; if (dog_xpos !== 12'd100) begin errors++; $display("FAIL abort_prep_x got %0d need 100", dog_xpos); end
    abort = 1'b1; frame_tick = 1'b1; cyc(); abort = 1'b0; frame_tick = 1'b0;
    checks++; if (dog_visible !== 1'b0 || busy !== 1'b0 || dog_xpos !== 12'd100 || done !== 1'b0) begin
      errors++; $display("FAIL abort_walk got vis %0b busy %0b x %0d done %0b need 0 0 100 0", dog_visible, busy, dog_xpos, done); end
    cyc();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %0b need 0", done); end
    peek_x = 12'd123; req_laugh = 1'b1; cyc(); req_laugh = 1'b0;
    checks++; if (busy !== 1'b1 || dog_select !== 4'd7 || dog_xpos !== 12'd123) begin
      errors++; $display("FAIL abort_then_laugh got busy %0b sel %0d x %0d need 1 7 123", busy, dog_select, dog_xpos); end
  endtask

  task automatic test_random();
    bit m_act;
    for (int c = 0; c < 6000; c++) begin
      frame_tick  = ($urandom_range(0, 2) != 0);
      start_intro = ($urandom_range(0, 99) == 0);
      req_bird    = ($urandom_range(0, 39) == 0);
      req_laugh   = ($urandom_range(0, 39) == 0);
      abort       = ($urandom_range(0, 799) == 0);
      rst_n       = ($urandom_range(0, 2999) != 0);
      peek_x      = 12'($urandom_range(0, 4095));
      cyc();
      m_act = !(m_phase == P_IDLE || m_phase == P_HIDDEN);
      checks++; if (dog_select !== 4'(m_sel) || dog_bird_mode !== m_bird) begin
        errors++; $display("FAIL rnd_sel_bird cyc %0d got %0d/%0b need %0d/%0b", c, dog_select, dog_bird_mode, m_sel, m_bird); end
      checks++; if (dog_xpos !== 12'(m_x) || dog_ypos !== 12'(m_y)) begin
        errors++; $display("FAIL rnd_pos cyc %0d got %0d,%0d need %0d,%0d", c, dog_xpos, dog_ypos, m_x, m_y); end
      checks++; if (dog_visible !== m_act || busy !== m_act || done !== m_done) begin
        errors++; $display("FAIL rnd_flags cyc %0d got vis %0b busy %0b done %0b need %0b %0b %0b", c, dog_visible, busy, done, m_act, m_act, m_done); end
    end
    frame_tick = 1'b0; start_intro = 1'b0; req_bird = 1'b0; req_laugh = 1'b0; abort = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_intro();
    test_peek_bird();
    test_peek_laugh();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dog_anim_ctrl.md
Name: dog_anim_ctrl

Overview:
Frame-based animation sequencer for the dog sprite. It drives the dog ROM frame select and the sprite position and visibility for the dog draw stage. It plays the intro walk/sniff/jump sequence, then the between-rounds peek: dog holding a bird, or dog laughing. The game FSM triggers it, and all motion advances once per frame_tick (one pulse per video frame).

Parameters:
X_START, 0, intro walk start x (px)
X_SNIFF, 200, x at which the walk ends and the sniff begins
STEP_PX, 2, walk x increment per frame_tick
FRAMES_PER_STEP, 6, frame_ticks per walk/laugh animation frame
SNIFF_FRAMES, 30, frame_ticks spent sniffing
JUMP_FRAMES, 16, frame_ticks per jump half (up or down)
JUMP_PX, 3, y change per frame_tick while jumping
Y_GROUND, 560, dog y on the ground
Y_HIDE, 600, dog y when fully behind the grass (peek start/end)
PEEK_FRAMES, 20, frame_ticks for peek rise and for peek fall
PEEK_PX, 2, y change per frame_tick while peeking
HOLD_FRAMES, 60, frame_ticks the peek pose is held

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
frame_tick  in  1  single-cycle pulse, once per frame
start_intro  in  1  pulse: begin the intro sequence
req_bird  in  1  pulse: peek holding a bird
req_laugh  in  1  pulse: peek laughing
peek_x  in  12  x for the peek, latched on an accepted request
abort  in  1  pulse: stop the animation, hide the dog
dog_select  out  4  dog ROM frame index 0..8
dog_bird_mode  out  1  1 = draw stage uses the dog_bird image
dog_xpos  out  12  sprite x
dog_ypos  out  12  sprite y
dog_visible  out  1  sprite enabled
busy  out  1  sequence in progress
done  out  1  single-cycle pulse at sequence end

Behaviour:
- All outputs are registered. Reset values: dog_select 0, dog_bird_mode 0, dog_xpos X_START, dog_ypos Y_GROUND, dog_visible 0, busy 0, done 0, state IDLE. Reset applies mid-sequence with the same result.
- States: IDLE, WALK, SNIFF, JUMP_UP, JUMP_DOWN, HIDDEN, PEEK_RISE, PEEK_HOLD, PEEK_FALL.
- Timers (8-bit tick counter, 3-bit animation counter) change only on cycles with frame_tick=1 and clear on every state change.
- IDLE:
  - start_intro -> WALK on the next clk.
  - Entry to WALK sets x=X_START, y=Y_GROUND, select 0, visible 1, busy 1.
  - req_bird and req_laugh are ignored in IDLE.
- WALK, per tick:
  - x += STEP_PX.
  - The animation counter counts 0..FRAMES_PER_STEP-1. On wrap, select advances 0->1->2->3->0.
  - When the updated x >= X_SNIFF, go to SNIFF. x saturates at X_SNIFF.
- SNIFF: select 4. After SNIFF_FRAMES ticks -> JUMP_UP.
- JUMP_UP: select 5, y -= JUMP_PX per tick. After JUMP_FRAMES ticks -> JUMP_DOWN.
- JUMP_DOWN: select 6, y += JUMP_PX per tick. After JUMP_FRAMES ticks, y equals Y_GROUND exactly -> HIDDEN.
- HIDDEN:
  - visible 0, busy 0, dog_bird_mode 0.
  - done pulses for exactly one cycle on entry from JUMP_DOWN or PEEK_FALL.
  - Accepts req_bird or req_laugh. If both arrive in the same cycle, bird wins.
  - On accept: latch peek_x into x, set y=Y_HIDE, visible 1, busy 1 -> PEEK_RISE.
  - Bird: dog_bird_mode 1, select 0. Laugh: dog_bird_mode 0, select 7.
  - start_intro in HIDDEN restarts the intro exactly as from IDLE.
- PEEK_RISE: y -= PEEK_PX per tick. After PEEK_FRAMES ticks -> PEEK_HOLD.
- PEEK_HOLD: position fixed for HOLD_FRAMES ticks -> PEEK_FALL. In laugh mode select toggles 7<->8 every FRAMES_PER_STEP ticks.
- PEEK_FALL:
  - y += PEEK_PX per tick. After PEEK_FRAMES ticks, y = Y_HIDE -> HIDDEN.
  - The laugh toggle continues through the fall.
- Requests while busy=1 are dropped, not queued. This includes start_intro during a sequence.
- abort in any non-IDLE state -> HIDDEN on the next clk with no done pulse. abort has priority over a same-cycle frame_tick and over a same-cycle request.
- frame_tick coinciding with a state change: the tick is consumed by the transition and does not count in the new state.
- Position arithmetic is 12-bit unsigned. Parameters must keep y within 0..4095; no wrap checking is done.

Test Plan:
- Reset mid-JUMP_UP -> next cycle: select 0, x 0, y 560, visible 0, busy 0, state IDLE; a subsequent req_bird is ignored.
- start_intro, then 100 frame_ticks -> x=200, select 0 (16 wraps), state SNIFF, select 4; after 30 more ticks select 5.
- Continue the intro -> after 16 ticks y=512; after 16 more y=560. Then visible 0, done high for exactly 1 clk, busy 0.
- In HIDDEN, req_bird and req_laugh in the same cycle with peek_x=300 -> dog_bird_mode 1, x=300, y=600. After 20 ticks y=560, held for 60 ticks, back at y=600 after 20 more, then done pulse.
- req_laugh -> select 7 during rise; in PEEK_HOLD select alternates 7/8 every 6 ticks (10 toggles over 60 ticks); a req_bird during the peek is dropped.
- abort during WALK at x=100 with a same-cycle frame_tick -> next clk visible 0, busy 0, x stays 100, no done pulse; a following req_laugh is accepted.
